tournament_choice_ctrl: RTL
===========================

// Module: tournament_choice_ctrl
// PURPOSE
//  Owns the tournament predictor's table of 2-bit choice (meta) counters.
//  - Serves lookups: produces choice_prediction for the global/local select mux.
//  - Applies resolve-time updates.
//  - Arbitrates the table's single access slot per cycle between lookups and updates.
//  - Sequences the post-reset table initialisation.
//  - Counter value >= 2'b10 selects global; < 2'b10 selects local.
// PARAMETERS
//  IDX_W     6      index width; table depth = 2**IDX_W entries
//  INIT_CTR  2'b01  value written to every entry during init (weakly local)
// PORTS
//  clk              in   1      clock, all state on rising edge
//  reset            in   1      asynchronous, active-high reset
//  lookup_v_i       in   1      lookup request valid
//  lookup_idx_i     in   IDX_W  lookup index (branch PC hash)
//  lookup_ready_o   out  1      lookup accepted this cycle when v & ready
//  choice_v_o       out  1      choice_o valid (1 cycle after accepted lookup)
//  choice_o         out  2      counter value; drives mux choice_prediction
//  upd_v_i          in   1      update request valid
//  upd_idx_i        in   IDX_W  index to update
//  upd_global_ok_i  in   1      global predictor was correct
//  upd_local_ok_i   in   1      local predictor was correct
//  upd_ready_o      out  1      update accepted this cycle when v & ready
//  init_busy_o      out  1      table initialisation in progress
// BEHAVIOUR
//  Reset values (async on reset=1):
//    state=INIT, init_idx=0, prio=UPD, choice_v_o=0, choice_o=2'b00,
//    init_busy_o=1, lookup_ready_o=0, upd_ready_o=0.
//  FSM:
//    INIT : writes INIT_CTR to entry init_idx each cycle, then init_idx++.
//           - Both readies held 0.
//           - After writing entry 2**IDX_W-1, go to RUN; no wrap.
//           - Exactly 2**IDX_W cycles after reset release.
//    RUN  : init_busy_o=0; stays in RUN until the next reset.
//  Arbitration in RUN (one table access per cycle; readies combinational on valids):
//    upd_ready_o    = !lookup_v_i | (prio==UPD)
//    lookup_ready_o = !upd_v_i    | (prio==LKP)
//    - Conflict cycle (both valid): the prio holder is granted; prio flips to the
//      other side at the clock edge.
//    - No conflict: prio unchanged.
//    - Result: under sustained contention, grants alternate U,L,U,L...
//  Lookup:
//    - Accepted at cycle N -> choice_v_o=1 and choice_o=table[idx] at cycle N+1.
//    - Otherwise choice_v_o=0 and choice_o holds its last value.
//  Update: accepted at cycle N -> table[idx] is written at edge end-of-N
//    (single-cycle read-modify-write).
//    - global_ok & !local_ok : ctr = (ctr==3) ? 3 : ctr+1  (saturate high)
//    - !global_ok & local_ok : ctr = (ctr==0) ? 0 : ctr-1  (saturate low)
//    - both ok / both wrong  : no change, but the access slot is still consumed.
//    - A lookup accepted at N+1 to the same idx returns the updated value;
//      no stale read.
//  Reset mid-operation:
//    - During INIT: restarts init at entry 0.
//    - During RUN: choice_v_o drops immediately; any in-flight update is dropped.
//    - The full INIT sequence repeats.
//  Arithmetic: the counter is 2-bit unsigned; never wraps 3->0 or 0->3.
// TESTING
//  1. Release reset -> init_busy_o=1 and both readies 0 for exactly 64 cycles;
//     then lookup idx 5 -> next cycle choice_v_o=1, choice_o=2'b01.
//  2. Three updates idx 5 (g_ok=1, l_ok=0) then lookup 5 -> choice_o=2'b11
//     (01->10->11->11). Then four updates (g_ok=0, l_ok=1) -> lookup gives 2'b00.
//  3. Updates idx 9 with (1,1) and (0,0) -> lookup idx 9 still 2'b01;
//     each update shows upd_ready_o=1.
//  4. Hold upd_v_i and lookup_v_i high for 4 cycles from RUN ->
//     grants U,L,U,L; choice_v_o high only in cycles after L grants.
//  5. Update idx 7 (1,0) at cycle N, lookup idx 7 at N+1 ->
//     choice_o=2'b10 at N+2.
//  6. Assert reset at init cycle 30 for 1 cycle -> init_busy_o high a full
//     64 cycles after release; all entries read back as 2'b01.

Source files
------------

// File: rtl/tournament_choice_ctrl.sv
// rtl/tournament_choice_ctrl.sv - tournament predictor choice-counter table with lookup/update arbitration
// Owns the 2-bit meta counters: post-reset init sweep, then one lookup or update per cycle.
module tournament_choice_ctrl #(
    parameter int          IDX_W    = 6,
    parameter logic [1:0]  INIT_CTR = 2'b01
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lookup_v_i,
    input  logic [IDX_W-1:0] lookup_idx_i,
    output logic             lookup_ready_o,
    output logic             choice_v_o,
    output logic [1:0]       choice_o,
    input  logic             upd_v_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_global_ok_i,
    input  logic             upd_local_ok_i,
    output logic             upd_ready_o,
    output logic             init_busy_o
);
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic { S_INIT, S_RUN } state_e;
    typedef enum logic { P_UPD, P_LKP } prio_e;

    state_e             state_q;
    prio_e              prio_q;
    logic [IDX_W-1:0]   init_idx_q;
    logic               choice_v_q;
    logic [1:0]         choice_q;
    logic [1:0]         table_q [DEPTH];

    logic               run;
    logic               upd_fire;
    logic               lkp_fire;
    logic [1:0]         upd_ctr;
    logic [1:0]         upd_ctr_d;
    logic               tbl_we;
    logic [IDX_W-1:0]   tbl_idx;
    logic [1:0]         tbl_data;

    assign run            = (state_q == S_RUN);
    assign upd_ready_o    = run & (!lookup_v_i | (prio_q == P_UPD));
    assign lookup_ready_o = run & (!upd_v_i | (prio_q == P_LKP));
    assign upd_fire       = upd_v_i & upd_ready_o;
    assign lkp_fire       = lookup_v_i & lookup_ready_o;
    assign init_busy_o    = (state_q == S_INIT);
    assign choice_v_o     = choice_v_q;
    assign choice_o       = choice_q;
    assign upd_ctr        = table_q[upd_idx_i];

    // Saturating counter step; agreement between predictors leaves it unchanged.
    always_comb begin
        upd_ctr_d = upd_ctr;
        if (upd_global_ok_i && !upd_local_ok_i && upd_ctr != 2'b11)
            upd_ctr_d = upd_ctr + 2'b01;
        else if (!upd_global_ok_i && upd_local_ok_i && upd_ctr != 2'b00)
            upd_ctr_d = upd_ctr - 2'b01;
    end

    always_comb begin
        tbl_we   = 1'b0;
        tbl_idx  = upd_idx_i;
        tbl_data = upd_ctr_d;
        if (!run) begin
            tbl_we   = 1'b1;
            tbl_idx  = init_idx_q;
            tbl_data = INIT_CTR;
        end else if (upd_fire) begin
            tbl_we   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tbl_we)
            table_q[tbl_idx] <= tbl_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_INIT;
            init_idx_q <= '0;
            prio_q     <= P_UPD;
            choice_v_q <= 1'b0;
            choice_q   <= 2'b00;
        end else begin
            choice_v_q <= lkp_fire;
            if (lkp_fire)
                choice_q <= table_q[lookup_idx_i];
            case (state_q)
                S_INIT: begin
                    if (init_idx_q == {IDX_W{1'b1}})
                        state_q <= S_RUN;
                    else
                        init_idx_q <= init_idx_q + 1'b1;
                end
                S_RUN: begin
                    if (lookup_v_i && upd_v_i)
                        prio_q <= (prio_q == P_UPD) ? P_LKP : P_UPD;
                end
                default: state_q <= S_INIT;
            endcase
        end
    end
endmodule
